spi_word_slave: RTL and testbench

Parametrised SPI slave for the FPGA fabric. It synchronises SCK, SSEL and MOSI to the system clock and supports all four CPOL/CPHA modes and a configurable word width and bit order. Back-to-back multi-word frames are supported, with a valid/ready receive port and a single-entry transmit holding buffer. It sits between the external SPI pins and the user logic, and is the generalised successor to the fixed 8-bit mode-0 slave.

---
 rtl/spi_word_slave.sv | 269 ++++++++++++++++++++++++++
 tb/tb_spi_word_slave.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_word_slave.sv
// -----------------------------------------------------------------------------
// spi_word_slave
//
// SPI slave running entirely in the system clock domain. SCK, SSEL and MOSI are
// oversampled through two-flop synchronisers plus one edge-detect stage. All
// four CPOL/CPHA modes, any word width >= 2 and either bit order are handled
// by parameters. Back-to-back words inside one SSEL frame are supported.
// Received words are offered on a valid/ready port. Transmit words are staged
// in a single-entry holding buffer.
//
// Parameters
//   WIDTH      word length in bits (>= 2)
//   CPOL       SCK idle level
//   CPHA       0: sample on leading edge, 1: sample on trailing edge
//   MSB_FIRST  1: MSB first on both lines, 0: LSB first
//
// Ports
//   clk, rst_n          system clock, asynchronous active-low reset
//   sck, ssel, mosi     raw SPI pins (asynchronous to clk)
//   miso, miso_oe       slave data out and its tri-state enable
//   rx_data/rx_valid/rx_ready   received word, valid/ready handshake
//   tx_data/tx_valid/tx_ready   next word to send, valid/ready handshake
//   busy                synchronised SSEL is active
//
// Optional feature (macro SPI_SLAVE_STATUS_EN)
//   rx_overrun   sticky: a word completed while rx_valid=1 and rx_ready=0
//   tx_underrun  sticky: a load event found the holding buffer empty
//   status_clr   clears both flags; a set in the same cycle wins
// -----------------------------------------------------------------------------
module spi_word_slave #(
    parameter int WIDTH     = 8,
    parameter bit CPOL      = 1'b0,
    parameter bit CPHA      = 1'b0,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sck,
    input  logic             ssel,
    input  logic             mosi,
    output logic             miso,
    output logic             miso_oe,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    input  logic             rx_ready,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic             busy
`ifdef SPI_SLAVE_STATUS_EN
    ,
    output logic             rx_overrun,
    output logic             tx_underrun,
    input  logic             status_clr
`endif
);

    localparam int              CW       = $clog2(WIDTH);
    localparam logic [CW-1:0]   LAST_BIT = CW'(WIDTH - 1);

    // Synchroniser and edge-detect stages
    logic sck_meta_q,  sck_sync_q,  sck_prev_q;
    logic ssel_meta_q, ssel_sync_q, ssel_prev_q;
    logic mosi_meta_q, mosi_sync_q;

    // Datapath state
    logic [CW-1:0]    bitcnt_q,   bitcnt_d;
    logic [WIDTH-1:0] rx_shift_q, rx_shift_d;
    logic [WIDTH-1:0] rx_data_q,  rx_data_d;
    logic             rx_valid_q, rx_valid_d;
    logic             word_seen_q, word_seen_d;
    logic [WIDTH-1:0] tx_shift_q, tx_shift_d;
    logic [WIDTH-1:0] tx_buf_q,   tx_buf_d;
    logic             tx_empty_q, tx_empty_d;
    logic             busy_q;

    // Decoded events
    logic sck_rise_s, sck_fall_s, lead_s, trail_s;
    logic active_s, ssel_assert_s, ssel_release_s;
    logic sample_s, shift_s, load_s, word_done_s, underrun_s, accept_s;

    // Two-flop synchronisers followed by one edge-detect register. SCK flops
    // reset to the idle level and SSEL flops to inactive so reset release
    // cannot fake an edge or a frame start. MOSI shares the SCK depth so the
    // sampled bit stays aligned with the detected edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_meta_q  <= CPOL;
            sck_sync_q  <= CPOL;
            sck_prev_q  <= CPOL;
            ssel_meta_q <= 1'b1;
            ssel_sync_q <= 1'b1;
            ssel_prev_q <= 1'b1;
            mosi_meta_q <= 1'b0;
            mosi_sync_q <= 1'b0;
        end else begin
            sck_meta_q  <= sck;
            sck_sync_q  <= sck_meta_q;
            sck_prev_q  <= sck_sync_q;
            ssel_meta_q <= ssel;
            ssel_sync_q <= ssel_meta_q;
            ssel_prev_q <= ssel_sync_q;
            mosi_meta_q <= mosi;
            mosi_sync_q <= mosi_meta_q;
        end
    end

    // Edge classification: leading/trailing from CPOL, sample/shift from CPHA
    always_comb begin
        sck_rise_s     = sck_sync_q & ~sck_prev_q;
        sck_fall_s     = ~sck_sync_q & sck_prev_q;
        lead_s         = CPOL ? sck_fall_s : sck_rise_s;
        trail_s        = CPOL ? sck_rise_s : sck_fall_s;
        active_s       = ~ssel_sync_q;
        ssel_assert_s  = ssel_prev_q & ~ssel_sync_q;
        ssel_release_s = ~ssel_prev_q & ssel_sync_q;
        sample_s       = active_s & (CPHA ? trail_s : lead_s);
        shift_s        = active_s & (CPHA ? lead_s : trail_s);
        // With CPHA=0 the first bit must already be on MISO before the first
        // edge, so the first word loads at frame start. Later words load on
        // the shift edge that follows a completed word.
        if (CPHA) begin
            load_s = shift_s & (bitcnt_q == {CW{1'b0}});
        end else begin
            load_s = ssel_assert_s
                   | (shift_s & (bitcnt_q == {CW{1'b0}}) & word_seen_q);
        end
    end

    // Receive path: shift register, bit counter, word completion, rx handshake
    always_comb begin
        bitcnt_d    = bitcnt_q;
        rx_shift_d  = rx_shift_q;
        rx_data_d   = rx_data_q;
        word_seen_d = word_seen_q;
        word_done_s = 1'b0;
        if (ssel_release_s || ssel_assert_s) begin
            // Frame boundary: any partial word is dropped
            bitcnt_d    = {CW{1'b0}};
            rx_shift_d  = {WIDTH{1'b0}};
            word_seen_d = 1'b0;
        end else if (sample_s) begin
            if (MSB_FIRST) begin
                rx_shift_d = {rx_shift_q[WIDTH-2:0], mosi_sync_q};
            end else begin
                rx_shift_d = {mosi_sync_q, rx_shift_q[WIDTH-1:1]};
            end
            if (bitcnt_q == LAST_BIT) begin
                bitcnt_d    = {CW{1'b0}};
                rx_data_d   = rx_shift_d;
                word_done_s = 1'b1;
                word_seen_d = 1'b1;
            end else begin
                bitcnt_d = bitcnt_q + CW'(1'b1);
            end
        end else begin
            bitcnt_d = bitcnt_q;
        end
        // A completion wins over a consume in the same cycle
        if (word_done_s) begin
            rx_valid_d = 1'b1;
        end else if (rx_valid_q && rx_ready) begin
            rx_valid_d = 1'b0;
        end else begin
            rx_valid_d = rx_valid_q;
        end
    end

    // Transmit path: load/shift of the tx register and the holding buffer
    always_comb begin
        tx_shift_d = tx_shift_q;
        tx_buf_d   = tx_buf_q;
        tx_empty_d = tx_empty_q;
        underrun_s = 1'b0;
        accept_s   = tx_valid & tx_empty_q;
        if (load_s) begin
            if (!tx_empty_q) begin
                tx_shift_d = tx_buf_q;
                tx_empty_d = 1'b1;
            end else begin
                tx_shift_d = {WIDTH{1'b0}};
                underrun_s = 1'b1;
            end
        end else if (shift_s) begin
            if (MSB_FIRST) begin
                tx_shift_d = {tx_shift_q[WIDTH-2:0], 1'b0};
            end else begin
                tx_shift_d = {1'b0, tx_shift_q[WIDTH-1:1]};
            end
        end else begin
            tx_shift_d = tx_shift_q;
        end
        // The handshake uses the pre-load buffer state, so a word offered in
        // the load cycle is kept for the following word, never bypassed.
        if (accept_s) begin
            tx_buf_d   = tx_data;
            tx_empty_d = 1'b0;
        end else begin
            tx_buf_d = tx_buf_q;
        end
    end

    // Datapath state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bitcnt_q    <= {CW{1'b0}};
            rx_shift_q  <= {WIDTH{1'b0}};
            rx_data_q   <= {WIDTH{1'b0}};
            rx_valid_q  <= 1'b0;
            word_seen_q <= 1'b0;
            tx_shift_q  <= {WIDTH{1'b0}};
            tx_buf_q    <= {WIDTH{1'b0}};
            tx_empty_q  <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            bitcnt_q    <= bitcnt_d;
            rx_shift_q  <= rx_shift_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            word_seen_q <= word_seen_d;
            tx_shift_q  <= tx_shift_d;
            tx_buf_q    <= tx_buf_d;
            tx_empty_q  <= tx_empty_d;
            busy_q      <= active_s;
        end
    end

    assign miso     = MSB_FIRST ? tx_shift_q[WIDTH-1] : tx_shift_q[0];
    assign miso_oe  = busy_q;
    assign busy     = busy_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign tx_ready = tx_empty_q;

`ifdef SPI_SLAVE_STATUS_EN
    logic rx_overrun_q;
    logic tx_underrun_q;
    logic overrun_s;

    assign overrun_s = word_done_s & rx_valid_q & ~rx_ready;

    // Sticky status flags; a set event takes priority over status_clr
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_overrun_q  <= 1'b0;
            tx_underrun_q <= 1'b0;
        end else begin
            if (overrun_s) begin
                rx_overrun_q <= 1'b1;
            end else if (status_clr) begin
                rx_overrun_q <= 1'b0;
            end else begin
                rx_overrun_q <= rx_overrun_q;
            end
            if (underrun_s) begin
                tx_underrun_q <= 1'b1;
            end else if (status_clr) begin
                tx_underrun_q <= 1'b0;
            end else begin
                tx_underrun_q <= tx_underrun_q;
            end
        end
    end

    assign rx_overrun  = rx_overrun_q;
    assign tx_underrun = tx_underrun_q;
`endif

endmodule

// File: tb/tb_spi_word_slave.sv
// -----------------------------------------------------------------------------
// tb_spi_word_slave
//
// Directed bench with four slave instances:
//   u0: mode 0, WIDTH=8,  MSB first
//   u1: mode 1, WIDTH=8,  MSB first
//   u2: mode 2, WIDTH=16, LSB first
//   u3: mode 3, WIDTH=8,  MSB first
// A bit-banged SPI master drives each one with SCK half period of H clocks.
// Status flag checks are compiled only when SPI_SLAVE_STATUS_EN is defined.
// -----------------------------------------------------------------------------
module tb_spi_word_slave;

    localparam int H = 8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [3:0] sck_s, ssel_s, miso_s, miso_oe_s, busy_s;
    logic [3:0] rx_valid_s, rx_ready_s, tx_valid_s, tx_ready_s;
    logic       mosi_s;
    logic [7:0]  rxd0, rxd1, rxd3, txd0, txd1, txd3;
    logic [15:0] rxd2, txd2;
`ifdef SPI_SLAVE_STATUS_EN
    logic [3:0] status_clr_s, rx_ovr_s, tx_und_s;
`endif

    int n_cmp = 0;
    int n_err = 0;

    logic [15:0] q0[$], q1[$], q2[$], q3[$];
    logic [15:0] rw;
    logic [15:0] r3 [3];

    spi_word_slave #(.WIDTH(8), .CPOL(1'b0), .CPHA(1'b0), .MSB_FIRST(1'b1)) u0 (
        .clk(clk), .rst_n(rst_n), .sck(sck_s[0]), .ssel(ssel_s[0]), .mosi(mosi_s),
        .miso(miso_s[0]), .miso_oe(miso_oe_s[0]), .rx_data(rxd0), .rx_valid(rx_valid_s[0]),
        .rx_ready(rx_ready_s[0]), .tx_data(txd0), .tx_valid(tx_valid_s[0]),
        .tx_ready(tx_ready_s[0]), .busy(busy_s[0])
`ifdef SPI_SLAVE_STATUS_EN
        , .rx_overrun(rx_ovr_s[0]), .tx_underrun(tx_und_s[0]), .status_clr(status_clr_s[0])
`endif
    );

    spi_word_slave #(.WIDTH(8), .CPOL(1'b0), .CPHA(1'b1), .MSB_FIRST(1'b1)) u1 (
        .clk(clk), .rst_n(rst_n), .sck(sck_s[1]), .ssel(ssel_s[1]), .mosi(mosi_s),
        .miso(miso_s[1]), .miso_oe(miso_oe_s[1]), .rx_data(rxd1), .rx_valid(rx_valid_s[1]),
        .rx_ready(rx_ready_s[1]), .tx_data(txd1), .tx_valid(tx_valid_s[1]),
        .tx_ready(tx_ready_s[1]), .busy(busy_s[1])
`ifdef SPI_SLAVE_STATUS_EN
        , .rx_overrun(rx_ovr_s[1]), .tx_underrun(tx_und_s[1]), .status_clr(status_clr_s[1])
`endif
    );

    spi_word_slave #(.WIDTH(16), .CPOL(1'b1), .CPHA(1'b0), .MSB_FIRST(1'b0)) u2 (
        .clk(clk), .rst_n(rst_n), .sck(sck_s[2]), .ssel(ssel_s[2]), .mosi(mosi_s),
        .miso(miso_s[2]), .miso_oe(miso_oe_s[2]), .rx_data(rxd2), .rx_valid(rx_valid_s[2]),
        .rx_ready(rx_ready_s[2]), .tx_data(txd2), .tx_valid(tx_valid_s[2]),
        .tx_ready(tx_ready_s[2]), .busy(busy_s[2])
`ifdef SPI_SLAVE_STATUS_EN
        , .rx_overrun(rx_ovr_s[2]), .tx_underrun(tx_und_s[2]), .status_clr(status_clr_s[2])
`endif
    );

    spi_word_slave #(.WIDTH(8), .CPOL(1'b1), .CPHA(1'b1), .MSB_FIRST(1'b1)) u3 (
        .clk(clk), .rst_n(rst_n), .sck(sck_s[3]), .ssel(ssel_s[3]), .mosi(mosi_s),
        .miso(miso_s[3]), .miso_oe(miso_oe_s[3]), .rx_data(rxd3), .rx_valid(rx_valid_s[3]),
        .rx_ready(rx_ready_s[3]), .tx_data(txd3), .tx_valid(tx_valid_s[3]),
        .tx_ready(tx_ready_s[3]), .busy(busy_s[3])
`ifdef SPI_SLAVE_STATUS_EN
        , .rx_overrun(rx_ovr_s[3]), .tx_underrun(tx_und_s[3]), .status_clr(status_clr_s[3])
`endif
    );

    // Record every rx handshake (it completes on the following rising edge)
    always @(negedge clk) begin
        if (rx_valid_s[0] && rx_ready_s[0]) q0.push_back({8'h00, rxd0});
        if (rx_valid_s[1] && rx_ready_s[1]) q1.push_back({8'h00, rxd1});
        if (rx_valid_s[2] && rx_ready_s[2]) q2.push_back(rxd2);
        if (rx_valid_s[3] && rx_ready_s[3]) q3.push_back({8'h00, rxd3});
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push_tx(input int idx, input logic [15:0] w);
        case (idx)
            0:       txd0 = w[7:0];
            1:       txd1 = w[7:0];
            2:       txd2 = w;
            default: txd3 = w[7:0];
        endcase
        tx_valid_s[idx] = 1'b1;
        @(negedge clk);
        tx_valid_s[idx] = 1'b0;
    endtask

    task automatic frame_start(input int idx);
        ssel_s[idx] = 1'b0;
        repeat (H) @(negedge clk);
    endtask

    task automatic frame_end(input int idx);
        repeat (H) @(negedge clk);
        ssel_s[idx] = 1'b1;
        repeat (H) @(negedge clk);
    endtask

    // Bit-banged master: sends nbits of txw and collects MISO on its sample edge
    task automatic xfer_word(input int idx, input bit cpol, input bit cpha, input bit msb,
                             input int width, input int nbits, input logic [15:0] txw,
                             output logic [15:0] rxw);
        int bp;
        rxw = 16'h0000;
        for (int b = 0; b < nbits; b++) begin
            bp = msb ? (width - 1 - b) : b;
            if (!cpha) begin
                mosi_s = txw[bp];
                repeat (H) @(negedge clk);
                rxw[bp] = miso_s[idx];
                sck_s[idx] = ~cpol;
                repeat (H) @(negedge clk);
                sck_s[idx] = cpol;
            end else begin
                sck_s[idx] = ~cpol;
                mosi_s = txw[bp];
                repeat (H) @(negedge clk);
                rxw[bp] = miso_s[idx];
                sck_s[idx] = cpol;
                repeat (H) @(negedge clk);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n      = 1'b0;
        sck_s      = 4'b1100;
        ssel_s     = 4'b1111;
        mosi_s     = 1'b0;
        rx_ready_s = 4'b1111;
        tx_valid_s = 4'b0000;
        txd0 = 8'h00; txd1 = 8'h00; txd3 = 8'h00; txd2 = 16'h0000;
`ifdef SPI_SLAVE_STATUS_EN
        status_clr_s = 4'b0000;
`endif
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // Reset state
        check_eq("rst_miso",     32'(miso_s),     32'h0);
        check_eq("rst_miso_oe",  32'(miso_oe_s),  32'h0);
        check_eq("rst_busy",     32'(busy_s),     32'h0);
        check_eq("rst_rx_valid", 32'(rx_valid_s), 32'h0);
        check_eq("rst_tx_ready", 32'(tx_ready_s), 32'hF);
        check_eq("rst_rx_data0", 32'(rxd0),       32'h0);
        check_eq("rst_rx_data2", 32'(rxd2),       32'h0);
`ifdef SPI_SLAVE_STATUS_EN
        check_eq("rst_overrun",  32'(rx_ovr_s),   32'h0);
        check_eq("rst_underrun", 32'(tx_und_s),   32'h0);
`endif

        // Mode 0: preload 0x3C, master sends 0xA5
        push_tx(0, 16'h003C);
        check_eq("t1_tx_ready_full", 32'(tx_ready_s[0]), 32'h0);
        q0.delete();
        frame_start(0);
        check_eq("t1_busy",    32'(busy_s[0]),    32'h1);
        check_eq("t1_miso_oe", 32'(miso_oe_s[0]), 32'h1);
        check_eq("t1_tx_ready_loaded", 32'(tx_ready_s[0]), 32'h1);
        xfer_word(0, 1'b0, 1'b0, 1'b1, 8, 8, 16'h00A5, rw);
        frame_end(0);
        check_eq("t1_rx_count",  32'(q0.size()), 32'h1);
        check_eq("t1_rx_word",   32'(q0[0]),     32'hA5);
        check_eq("t1_master_rd", 32'(rw),        32'h3C);
        check_eq("t1_busy_end",  32'(busy_s[0]), 32'h0);

        // Mode 3: three-word frame, tx words fed as tx_ready rises
        push_tx(3, 16'h0011);
        q3.delete();
        frame_start(3);
        fork
            begin
                for (int w = 0; w < 3; w++)
                    xfer_word(3, 1'b1, 1'b1, 1'b1, 8, 8, 16'(w + 1), r3[w]);
            end
            begin
                for (int k = 1; k < 3; k++) begin
                    int t = 0;
                    while (!tx_ready_s[3] && t < 4000) begin
                        @(negedge clk);
                        t++;
                    end
                    check_eq("t2_tx_ready_rise", 32'(tx_ready_s[3]), 32'h1);
                    push_tx(3, (k == 1) ? 16'h0022 : 16'h0033);
                end
            end
        join
        frame_end(3);
        check_eq("t2_rx_count", 32'(q3.size()), 32'h3);
        check_eq("t2_rx_w0", 32'(q3[0]), 32'h01);
        check_eq("t2_rx_w1", 32'(q3[1]), 32'h02);
        check_eq("t2_rx_w2", 32'(q3[2]), 32'h03);
        check_eq("t2_rd_w0", 32'(r3[0]), 32'h11);
        check_eq("t2_rd_w1", 32'(r3[1]), 32'h22);
        check_eq("t2_rd_w2", 32'(r3[2]), 32'h33);

        // Mode 1 with empty tx buffer: zero fill
        q1.delete();
        frame_start(1);
        xfer_word(1, 1'b0, 1'b1, 1'b1, 8, 8, 16'h0096, rw);
        frame_end(1);
        check_eq("t3_master_rd", 32'(rw),        32'h00);
        check_eq("t3_rx_count",  32'(q1.size()), 32'h1);
        check_eq("t3_rx_word",   32'(q1[0]),     32'h96);
`ifdef SPI_SLAVE_STATUS_EN
        check_eq("t3_underrun",  32'(tx_und_s[1]), 32'h1);
        check_eq("t3_no_overrun", 32'(rx_ovr_s[1]), 32'h0);
`endif

        // Overrun: rx_ready held low across two words
        rx_ready_s[0] = 1'b0;
        frame_start(0);
        xfer_word(0, 1'b0, 1'b0, 1'b1, 8, 8, 16'h005A, rw);
        xfer_word(0, 1'b0, 1'b0, 1'b1, 8, 8, 16'h00C3, rw);
        frame_end(0);
        check_eq("t4_rx_data",  32'(rxd0),          32'hC3);
        check_eq("t4_rx_valid", 32'(rx_valid_s[0]), 32'h1);
`ifdef SPI_SLAVE_STATUS_EN
        check_eq("t4_overrun",  32'(rx_ovr_s[0]),   32'h1);
        status_clr_s[0] = 1'b1;
        @(negedge clk);
        status_clr_s[0] = 1'b0;
        @(negedge clk);
        check_eq("t4_overrun_clr",  32'(rx_ovr_s[0]), 32'h0);
        check_eq("t4_underrun_clr", 32'(tx_und_s[0]), 32'h0);
`endif
        rx_ready_s[0] = 1'b1;
        repeat (2) @(negedge clk);
        check_eq("t4_rx_consumed", 32'(rx_valid_s[0]), 32'h0);

        // Abort after 5 bits, then a clean frame
        q0.delete();
        frame_start(0);
        xfer_word(0, 1'b0, 1'b0, 1'b1, 8, 5, 16'h00FF, rw);
        frame_end(0);
        check_eq("t5_no_word",   32'(q0.size()),     32'h0);
        check_eq("t5_rx_valid",  32'(rx_valid_s[0]), 32'h0);
        check_eq("t5_bitcnt",    32'(u0.bitcnt_q),   32'h0);
        check_eq("t5_rx_kept",   32'(rxd0),          32'hC3);
        frame_start(0);
        xfer_word(0, 1'b0, 1'b0, 1'b1, 8, 8, 16'h0081, rw);
        frame_end(0);
        check_eq("t5_rx_count",  32'(q0.size()), 32'h1);
        check_eq("t5_rx_word",   32'(q0[0]),     32'h81);

        // WIDTH=16, LSB first, mode 2
        push_tx(2, 16'hBEEF);
        q2.delete();
        frame_start(2);
        check_eq("t6_first_miso", 32'(miso_s[2]), 32'h1);
        xfer_word(2, 1'b1, 1'b0, 1'b0, 16, 16, 16'h1234, rw);
        frame_end(2);
        check_eq("t6_rx_count",  32'(q2.size()), 32'h1);
        check_eq("t6_rx_word",   32'(q2[0]),     32'h1234);
        check_eq("t6_rx_data",   32'(rxd2),      32'h1234);
        check_eq("t6_master_rd", 32'(rw),        32'hBEEF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
